power_up_sequencer: RTL and testbench
=====================================

Name: power_up_sequencer

Overview:
Synthesizable, parametrised power-up sequencer for the G-15 core. It drives the power-cycle controls (CLEAR, OP/~OP, ATS, NT) and the GO switch through the full cold-start sequence, timed in 1 ms ticks from the existing timer. Tape read-in completion is taken from PL6_WAIT_FOR_TAPE, with an optional timeout. It supports a configurable number of loader blocks and an optional number-track step, and replaces hand-scripted bring-up stimulus in both simulation and on board.

Parameters:
CLEAR_TICKS, 150, ticks PWR_CLEAR held high
NOOP_LEAD_TICKS, 30, ticks ~OP low before OP rises
OP_TICKS, 60, ticks PWR_OP held high
NOOP_TRAIL_TICKS, 30, ticks ~OP stays low after OP falls
SETTLE_TICKS, 120, idle gap before each ATS/NT/GO step
ATS_TICKS, 30, ATS pulse width
NT_TICKS, 120, PWR_NT pulse width
LOAD_BLOCKS, 1, loader blocks read after the timing track (0 = none)
TAPE_TIMEOUT_TICKS, 0, max ticks waiting for tape (0 = no timeout)
CNT_W, 16, tick counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tick  in  1  1 ms single-cycle strobe from timer
start  in  1  single-cycle request to begin sequence
en_nt  in  1  1 = perform M19->number-track step (sampled at start)
wait_for_tape  in  1  PL6_WAIT_FOR_TAPE from reader
pwr_clear  out  1  PWR_CLEAR
pwr_no_clear  out  1  PWR_NO_CLEAR
pwr_op  out  1  PWR_OP
pwr_no_op  out  1  PWR_NO_OP
pwr_ats  out  1  PWR_ATS
pwr_nt  out  1  PWR_NT
sw_go  out  1  SW_GO
busy  out  1  sequence in progress
done  out  1  sequence complete, GO asserted
error  out  1  tape timeout occurred
state_o  out  4  current state encoding (debug)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: pwr_no_clear=1, pwr_no_op=1; all other outputs 0; state IDLE. An assertion of rst mid-sequence returns every output to these values on the next edge.
- pwr_no_clear is held at 1 in every state.
- Timed states: on entry the counter loads N-1. It decrements on each tick. The state exits on the tick where count==0, so each state lasts exactly N ticks. Non-timed cycles leave the counter unchanged.
- Elaboration $error if any *_TICKS parameter is 0, except TAPE_TIMEOUT_TICKS.
- States and outputs (unlisted outputs at reset value):
  IDLE: start -> CLEAR.
  CLEAR: pwr_clear=1.
  NOOP_LEAD: pwr_no_op=0.
  OP: pwr_no_op=0, pwr_op=1.
  NOOP_TRAIL: pwr_no_op=0.
  SET_TT: settle.
  ATS_TT: pwr_ats=1.
  WAIT_TT: wait for tape.
  SET_NT, NT: pwr_nt=1. Both are skipped when the latched en_nt is 0.
  SET_LD, ATS_LD, WAIT_LD: repeated LOAD_BLOCKS times; skipped entirely if 0.
  SET_GO: settle.
  RUN: sw_go=1, done=1.
  FAULT: error=1.
- busy=1 in every state except IDLE, RUN and FAULT.
- Tape wait:
  - A registered copy of wait_for_tape forms the falling-edge detect.
  - The detector is armed on entry to ATS_*. A fall during the ATS pulse is latched and consumed on entry to WAIT_*.
  - WAIT_* advances on the cycle after the fall is detected.
- Timeout: if TAPE_TIMEOUT_TICKS>0, WAIT_* counts ticks from entry. Expiry goes to FAULT.
- Tick and falling edge in the same cycle: the edge wins, no fault.
- Block counter: width $clog2(LOAD_BLOCKS+1). Cleared at start, incremented on WAIT_LD exit. Loops to SET_LD while count < LOAD_BLOCKS.
- start while busy or in RUN: ignored.
- start in FAULT: clears error and restarts at CLEAR.
- The tick strobe is assumed single-cycle. A tick on the cycle a state is entered counts toward that state.

Decomposition:
- Package g15_pwr_pkg: typedef enum logic [3:0] pwr_state_t (IDLE=0 … FAULT=15, explicit encodings so state_o is stable for debug).
- Single module. The edge detector and tick counter are inline; no sub-module is warranted.

Test Plan:
1. Params CLEAR=3, LEAD=2, OP=2, TRAIL=2, SETTLE=2, ATS=2, NT=2, LOAD_BLOCKS=1, en_nt=1. Pulse start, then drop wait_for_tape 5 ticks after each ATS -> pwr_clear high exactly 3 ticks; pwr_no_op low 6 ticks containing a 2-tick pwr_op; pwr_nt 2 ticks; sw_go=1, done=1 after the second tape fall + 2 ticks.
2. Same as test 1 with en_nt=0 -> pwr_nt never asserts; NT states never appear on state_o.
3. LOAD_BLOCKS=3 -> exactly 4 ATS pulses total; each pulse waits for its own fall.
4. wait_for_tape falls during the ATS pulse -> WAIT_* exits on its first cycle with no extra wait.
5. TAPE_TIMEOUT_TICKS=4, wait_for_tape held high -> FAULT after 4 ticks in WAIT_TT: error=1, pwr_ats=0, pwr_no_op=1. Then start -> error=0 and sequence restarts at CLEAR.
6. rst asserted during OP -> next edge pwr_op=0, pwr_no_op=1, busy=0, state_o=IDLE. start pulses while busy -> no effect on timing.

Source files
------------

// File: rtl/g15_pwr_pkg.sv
// Shared types for the G-15 power-up sequencer: state encoding (stable for debug
// readout on state_o) and small state-classification helpers.
package g15_pwr_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_CLEAR      = 4'd1,
        ST_NOOP_LEAD  = 4'd2,
        ST_OP         = 4'd3,
        ST_NOOP_TRAIL = 4'd4,
        ST_SET_TT     = 4'd5,
        ST_ATS_TT     = 4'd6,
        ST_WAIT_TT    = 4'd7,
        ST_SET_NT     = 4'd8,
        ST_NT         = 4'd9,
        ST_SET_LD     = 4'd10,
        ST_ATS_LD     = 4'd11,
        ST_WAIT_LD    = 4'd12,
        ST_SET_GO     = 4'd13,
        ST_RUN        = 4'd14,
        ST_FAULT      = 4'd15
    } pwr_state_t;

    function automatic logic is_timed(pwr_state_t s);
        case (s)
            ST_CLEAR, ST_NOOP_LEAD, ST_OP, ST_NOOP_TRAIL,
            ST_SET_TT, ST_ATS_TT, ST_SET_NT, ST_NT,
            ST_SET_LD, ST_ATS_LD, ST_SET_GO: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    function automatic logic is_wait(pwr_state_t s);
        return (s == ST_WAIT_TT) || (s == ST_WAIT_LD);
    endfunction

    function automatic logic is_ats(pwr_state_t s);
        return (s == ST_ATS_TT) || (s == ST_ATS_LD);
    endfunction

    function automatic logic is_busy(pwr_state_t s);
        return !((s == ST_IDLE) || (s == ST_RUN) || (s == ST_FAULT));
    endfunction

endpackage

// File: rtl/power_up_sequencer.sv
// Cold-start sequencer for the G-15 core: walks CLEAR, OP/~OP, ATS, NT and GO through
// their timed steps in 1 ms ticks, waiting on tape read-in between loader steps.
module power_up_sequencer
    import g15_pwr_pkg::*;
#(
    parameter int CLEAR_TICKS        = 150,
    parameter int NOOP_LEAD_TICKS    = 30,
    parameter int OP_TICKS           = 60,
    parameter int NOOP_TRAIL_TICKS   = 30,
    parameter int SETTLE_TICKS       = 120,
    parameter int ATS_TICKS          = 30,
    parameter int NT_TICKS           = 120,
    parameter int LOAD_BLOCKS        = 1,
    parameter int TAPE_TIMEOUT_TICKS = 0,
    parameter int CNT_W              = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       en_nt,
    input  logic       wait_for_tape,
    output logic       pwr_clear,
    output logic       pwr_no_clear,
    output logic       pwr_op,
    output logic       pwr_no_op,
    output logic       pwr_ats,
    output logic       pwr_nt,
    output logic       sw_go,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] state_o
);

    localparam int BLK_W = (LOAD_BLOCKS > 0) ? $clog2(LOAD_BLOCKS + 1) : 1;

    if ((CLEAR_TICKS == 0) || (NOOP_LEAD_TICKS == 0) || (OP_TICKS == 0) ||
        (NOOP_TRAIL_TICKS == 0) || (SETTLE_TICKS == 0) || (ATS_TICKS == 0) ||
        (NT_TICKS == 0)) begin : g_bad_ticks
        $error("power_up_sequencer: every step duration must be at least one tick");
    end

    pwr_state_t       state_r;
    pwr_state_t       state_next_s;
    pwr_state_t       after_tt_s;
    pwr_state_t       after_nt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [BLK_W-1:0] blk_cnt_r;
    logic             en_nt_r;
    logic             wft_r;
    logic             fall_latched_r;
    logic             fall_s;
    logic             tape_s;
    logic             expire_s;
    logic             timeout_s;
    logic             more_blocks_s;
    logic             enter_s;
    logic             launch_s;
    logic             counting_s;

    logic pwr_clear_s, pwr_op_s, pwr_no_op_s, pwr_ats_s, pwr_nt_s;
    logic sw_go_s, busy_s, done_s, error_s;
    logic pwr_clear_r, pwr_op_r, pwr_no_op_r, pwr_ats_r, pwr_nt_r;
    logic sw_go_r, busy_r, done_r, error_r;
    logic [3:0] state_o_r;

    function automatic logic [CNT_W-1:0] load_value(pwr_state_t s);
        case (s)
            ST_CLEAR:      return CNT_W'(CLEAR_TICKS - 1);
            ST_NOOP_LEAD:  return CNT_W'(NOOP_LEAD_TICKS - 1);
            ST_OP:         return CNT_W'(OP_TICKS - 1);
            ST_NOOP_TRAIL: return CNT_W'(NOOP_TRAIL_TICKS - 1);
            ST_SET_TT, ST_SET_NT, ST_SET_LD, ST_SET_GO:
                           return CNT_W'(SETTLE_TICKS - 1);
            ST_ATS_TT, ST_ATS_LD:
                           return CNT_W'(ATS_TICKS - 1);
            ST_NT:         return CNT_W'(NT_TICKS - 1);
            ST_WAIT_TT, ST_WAIT_LD:
                           return (TAPE_TIMEOUT_TICKS > 0) ? CNT_W'(TAPE_TIMEOUT_TICKS - 1)
                                                           : {CNT_W{1'b0}};
            default:       return {CNT_W{1'b0}};
        endcase
    endfunction

    // A fall caught during the ATS pulse stands in for a fall seen while waiting.
    assign fall_s        = wft_r & ~wait_for_tape;
    assign tape_s        = fall_s | fall_latched_r;
    assign expire_s      = tick & (cnt_r == {CNT_W{1'b0}});
    assign timeout_s     = (TAPE_TIMEOUT_TICKS > 0) & expire_s;
    assign more_blocks_s = ((32'(blk_cnt_r) + 32'd1) < 32'(LOAD_BLOCKS));
    assign launch_s      = start & ((state_r == ST_IDLE) | (state_r == ST_FAULT));
    assign enter_s       = (state_next_s != state_r);
    assign counting_s    = is_timed(state_r) | is_wait(state_r);
    assign after_nt_s    = (LOAD_BLOCKS > 0) ? ST_SET_LD : ST_SET_GO;
    assign after_tt_s    = en_nt_r ? ST_SET_NT : after_nt_s;

    // State register plus step counter, block counter and tape edge detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            cnt_r          <= {CNT_W{1'b0}};
            blk_cnt_r      <= {BLK_W{1'b0}};
            en_nt_r        <= 1'b0;
            wft_r          <= 1'b0;
            fall_latched_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            wft_r   <= wait_for_tape;
            if (enter_s) begin
                cnt_r <= load_value(state_next_s);
            end else if (tick && counting_s && (cnt_r != {CNT_W{1'b0}})) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
            if (launch_s) begin
                en_nt_r   <= en_nt;
                blk_cnt_r <= {BLK_W{1'b0}};
            end else if ((state_r == ST_WAIT_LD) && tape_s) begin
                blk_cnt_r <= blk_cnt_r + BLK_W'(1);
            end
            if (enter_s && is_ats(state_next_s)) begin
                fall_latched_r <= 1'b0;
            end else if (is_ats(state_r) && fall_s) begin
                fall_latched_r <= 1'b1;
            end else if (is_wait(state_r) && tape_s) begin
                fall_latched_r <= 1'b0;
            end
        end
    end

    // Next-state selection.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_FAULT: begin
                if (start) state_next_s = ST_CLEAR;
                else       state_next_s = state_r;
            end
            ST_CLEAR: begin
                if (expire_s) state_next_s = ST_NOOP_LEAD;
                else          state_next_s = state_r;
            end
            ST_NOOP_LEAD: begin
                if (expire_s) state_next_s = ST_OP;
                else          state_next_s = state_r;
            end
            ST_OP: begin
                if (expire_s) state_next_s = ST_NOOP_TRAIL;
                else          state_next_s = state_r;
            end
            ST_NOOP_TRAIL: begin
                if (expire_s) state_next_s = ST_SET_TT;
                else          state_next_s = state_r;
            end
            ST_SET_TT: begin
                if (expire_s) state_next_s = ST_ATS_TT;
                else          state_next_s = state_r;
            end
            ST_ATS_TT: begin
                if (expire_s) state_next_s = ST_WAIT_TT;
                else          state_next_s = state_r;
            end
            ST_WAIT_TT: begin
                if (tape_s)         state_next_s = after_tt_s;
                else if (timeout_s) state_next_s = ST_FAULT;
                else                state_next_s = state_r;
            end
            ST_SET_NT: begin
                if (expire_s) state_next_s = ST_NT;
                else          state_next_s = state_r;
            end
            ST_NT: begin
                if (expire_s) state_next_s = after_nt_s;
                else          state_next_s = state_r;
            end
            ST_SET_LD: begin
                if (expire_s) state_next_s = ST_ATS_LD;
                else          state_next_s = state_r;
            end
            ST_ATS_LD: begin
                if (expire_s) state_next_s = ST_WAIT_LD;
                else          state_next_s = state_r;
            end
            ST_WAIT_LD: begin
                if (tape_s)         state_next_s = more_blocks_s ? ST_SET_LD : ST_SET_GO;
                else if (timeout_s) state_next_s = ST_FAULT;
                else                state_next_s = state_r;
            end
            ST_SET_GO: begin
                if (expire_s) state_next_s = ST_RUN;
                else          state_next_s = state_r;
            end
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs track state_r.
    always_comb begin
        pwr_clear_s = 1'b0;
        pwr_op_s    = 1'b0;
        pwr_no_op_s = 1'b1;
        pwr_ats_s   = 1'b0;
        pwr_nt_s    = 1'b0;
        sw_go_s     = 1'b0;
        done_s      = 1'b0;
        error_s     = 1'b0;
        busy_s      = is_busy(state_next_s);
        case (state_next_s)
            ST_CLEAR:      pwr_clear_s = 1'b1;
            ST_NOOP_LEAD:  pwr_no_op_s = 1'b0;
            ST_OP: begin
                pwr_no_op_s = 1'b0;
                pwr_op_s    = 1'b1;
            end
            ST_NOOP_TRAIL: pwr_no_op_s = 1'b0;
            ST_ATS_TT, ST_ATS_LD: pwr_ats_s = 1'b1;
            ST_NT:         pwr_nt_s = 1'b1;
            ST_RUN: begin
                sw_go_s = 1'b1;
                done_s  = 1'b1;
            end
            ST_FAULT:      error_s = 1'b1;
            default:       pwr_no_op_s = 1'b1;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwr_clear_r <= 1'b0;
            pwr_op_r    <= 1'b0;
            pwr_no_op_r <= 1'b1;
            pwr_ats_r   <= 1'b0;
            pwr_nt_r    <= 1'b0;
            sw_go_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            state_o_r   <= ST_IDLE;
        end else begin
            pwr_clear_r <= pwr_clear_s;
            pwr_op_r    <= pwr_op_s;
            pwr_no_op_r <= pwr_no_op_s;
            pwr_ats_r   <= pwr_ats_s;
            pwr_nt_r    <= pwr_nt_s;
            sw_go_r     <= sw_go_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            error_r     <= error_s;
            state_o_r   <= state_next_s;
        end
    end

    assign pwr_clear    = pwr_clear_r;
    assign pwr_no_clear = 1'b1;
    assign pwr_op       = pwr_op_r;
    assign pwr_no_op    = pwr_no_op_r;
    assign pwr_ats      = pwr_ats_r;
    assign pwr_nt       = pwr_nt_r;
    assign sw_go        = sw_go_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign error        = error_r;
    assign state_o      = state_o_r;

endmodule

// File: tb/tb_power_up_sequencer.sv
// Randomized bench: three sequencer configurations share one random stimulus stream and
// are compared every cycle against a phase-list model of the cold-start procedure.
module tb_power_up_sequencer;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst, tick, start, en_nt, wft;

    logic       clr_w  [NI];
    logic       nclr_w [NI];
    logic       op_w   [NI];
    logic       nop_w  [NI];
    logic       ats_w  [NI];
    logic       nt_w   [NI];
    logic       go_w   [NI];
    logic       busy_w [NI];
    logic       done_w [NI];
    logic       err_w  [NI];
    logic [3:0] st_w   [NI];

    int n_checks = 0;
    int n_errors = 0;

    // Model: each running sequence is a list of phases (state code, tick length).
    int ph_kind [NI][40];
    int ph_n    [NI][40];
    int ph_len  [NI];
    int m_mode  [NI];   // 0 idle, 1 running through phase list, 2 fault
    int m_idx   [NI];
    int m_rem   [NI];
    int m_wt    [NI];
    bit m_lat   [NI];
    bit wft_prev;

    always #5 clk = ~clk;

    power_up_sequencer #(
        .CLEAR_TICKS(3), .NOOP_LEAD_TICKS(2), .OP_TICKS(2), .NOOP_TRAIL_TICKS(2),
        .SETTLE_TICKS(2), .ATS_TICKS(2), .NT_TICKS(2), .LOAD_BLOCKS(1),
        .TAPE_TIMEOUT_TICKS(0), .CNT_W(16)
    ) u_dut0 (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .en_nt(en_nt), .wait_for_tape(wft),
        .pwr_clear(clr_w[0]), .pwr_no_clear(nclr_w[0]), .pwr_op(op_w[0]), .pwr_no_op(nop_w[0]),
        .pwr_ats(ats_w[0]), .pwr_nt(nt_w[0]), .sw_go(go_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .error(err_w[0]), .state_o(st_w[0])
    );

    power_up_sequencer #(
        .CLEAR_TICKS(3), .NOOP_LEAD_TICKS(2), .OP_TICKS(2), .NOOP_TRAIL_TICKS(2),
        .SETTLE_TICKS(2), .ATS_TICKS(2), .NT_TICKS(2), .LOAD_BLOCKS(3),
        .TAPE_TIMEOUT_TICKS(4), .CNT_W(8)
    ) u_dut1 (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .en_nt(en_nt), .wait_for_tape(wft),
        .pwr_clear(clr_w[1]), .pwr_no_clear(nclr_w[1]), .pwr_op(op_w[1]), .pwr_no_op(nop_w[1]),
        .pwr_ats(ats_w[1]), .pwr_nt(nt_w[1]), .sw_go(go_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .error(err_w[1]), .state_o(st_w[1])
    );

    power_up_sequencer #(
        .CLEAR_TICKS(1), .NOOP_LEAD_TICKS(1), .OP_TICKS(1), .NOOP_TRAIL_TICKS(1),
        .SETTLE_TICKS(1), .ATS_TICKS(1), .NT_TICKS(1), .LOAD_BLOCKS(0),
        .TAPE_TIMEOUT_TICKS(1), .CNT_W(16)
    ) u_dut2 (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .en_nt(en_nt), .wait_for_tape(wft),
        .pwr_clear(clr_w[2]), .pwr_no_clear(nclr_w[2]), .pwr_op(op_w[2]), .pwr_no_op(nop_w[2]),
        .pwr_ats(ats_w[2]), .pwr_nt(nt_w[2]), .sw_go(go_w[2]), .busy(busy_w[2]),
        .done(done_w[2]), .error(err_w[2]), .state_o(st_w[2])
    );

    function automatic int blocks_of(int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
    endfunction

    function automatic int timeout_of(int k);
        return (k == 0) ? 0 : ((k == 1) ? 4 : 1);
    endfunction

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic add_phase(int k, int kind, int n);
        ph_kind[k][ph_len[k]] = kind;
        ph_n[k][ph_len[k]]    = n;
        ph_len[k]++;
    endtask

    // Phase codes are the documented debug encodings shown on state_o.
    task automatic build_sequence(int k, bit with_nt);
        int s;
        s = (k == 2) ? 1 : 2;
        ph_len[k] = 0;
        add_phase(k, 1, (k == 2) ? 1 : 3);
        add_phase(k, 2, s);
        add_phase(k, 3, s);
        add_phase(k, 4, s);
        add_phase(k, 5, s);
        add_phase(k, 6, s);
        add_phase(k, 7, 0);
        if (with_nt) begin
            add_phase(k, 8, s);
            add_phase(k, 9, s);
        end
        for (int b = 0; b < blocks_of(k); b++) begin
            add_phase(k, 10, s);
            add_phase(k, 11, s);
            add_phase(k, 12, 0);
        end
        add_phase(k, 13, s);
        add_phase(k, 14, 0);
    endtask

    task automatic enter_phase(int k, int i);
        m_idx[k] = i;
        m_rem[k] = ph_n[k][i];
        m_wt[k]  = 0;
        if ((ph_kind[k][i] == 6) || (ph_kind[k][i] == 11)) m_lat[k] = 1'b0;
    endtask

    task automatic model_step(int k);
        int  kind;
        bit  fall;
        fall = wft_prev && !wft;
        if (rst) begin
            m_mode[k] = 0;
            m_lat[k]  = 1'b0;
        end else if (m_mode[k] != 1) begin
            if (start) begin
                build_sequence(k, en_nt);
                m_mode[k] = 1;
                enter_phase(k, 0);
            end
        end else begin
            kind = ph_kind[k][m_idx[k]];
            if (kind == 14) begin
                m_mode[k] = 1;
            end else if ((kind == 7) || (kind == 12)) begin
                if (fall || m_lat[k]) begin
                    m_lat[k] = 1'b0;
                    enter_phase(k, m_idx[k] + 1);
                end else if ((timeout_of(k) > 0) && tick) begin
                    m_wt[k]++;
                    if (m_wt[k] == timeout_of(k)) m_mode[k] = 2;
                end
            end else begin
                if (((kind == 6) || (kind == 11)) && fall) m_lat[k] = 1'b1;
                if (tick) begin
                    if (m_rem[k] == 1) enter_phase(k, m_idx[k] + 1);
                    else               m_rem[k]--;
                end
            end
        end
    endtask

    function automatic logic [13:0] expected_vec(int k);
        int code;
        logic [3:0] c4;
        code = (m_mode[k] == 0) ? 0 : ((m_mode[k] == 2) ? 15 : ph_kind[k][m_idx[k]]);
        c4 = 4'(code);
        return {c4, code == 1, 1'b1, code == 3, !((code >= 2) && (code <= 4)),
                (code == 6) || (code == 11), code == 9, code == 14,
                !((code == 0) || (code == 14) || (code == 15)), code == 14, code == 15};
    endfunction

    function automatic logic [13:0] observed_vec(int k);
        return {st_w[k], clr_w[k], nclr_w[k], op_w[k], nop_w[k], ats_w[k], nt_w[k],
                go_w[k], busy_w[k], done_w[k], err_w[k]};
    endfunction

    initial begin
        rst      = 1'b1;
        tick     = 1'b0;
        start    = 1'b0;
        en_nt    = 1'b0;
        wft      = 1'b1;
        wft_prev = 1'b0;
        for (int k = 0; k < NI; k++) begin
            m_mode[k] = 0;
            m_idx[k]  = 0;
            m_rem[k]  = 0;
            m_wt[k]   = 0;
            m_lat[k]  = 1'b0;
            ph_len[k] = 0;
        end
        @(posedge clk);
        #1;
        for (int cyc = 0; cyc < 30000; cyc++) begin
            rst   = (cyc < 2) || ($urandom_range(0, 399) == 0);
            tick  = !tick && ($urandom_range(0, 2) == 0);
            start = ($urandom_range(0, 29) == 0);
            en_nt = ($urandom_range(0, 1) == 1);
            if (wft) wft = ($urandom_range(0, 11) != 0);
            else     wft = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < NI; k++) model_step(k);
            wft_prev = rst ? 1'b0 : wft;
            @(posedge clk);
            #1;
            for (int k = 0; k < NI; k++) begin
                check_value($sformatf("%s_dut%0d", (cyc < 2) ? "reset" : "outputs", k),
                            32'(observed_vec(k)), 32'(expected_vec(k)));
            end
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
